// File: rtl/pong_scoreboard_if.sv
// Signal bundle between GameLogic and the scoreboard: goal/match pulses in,
// BCD scores, match status and HEX segment drives out.
interface pong_scoreboard_if;
  logic       goal_left;
  logic       goal_right;
  logic       new_match;
  logic [7:0] score_left;
  logic [7:0] score_right;
  logic       match_over;
  logic       winner;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  modport master (
    output goal_left, goal_right, new_match,
    input  score_left, score_right, match_over, winner,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );

  modport slave (
    input  goal_left, goal_right, new_match,
    output score_left, score_right, match_over, winner,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );
endinterface

// File: rtl/pong_scoreboard.sv
// BCD score keeper with end-of-match detection and blinking 7-segment display.
// Define SCOREBOARD_DEUCE_EN to require a two-point lead to win.
module pong_scoreboard #(
  parameter int unsigned WIN_SCORE = 11,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input logic              CLOCK2_50,
  input logic              rst,
  pong_scoreboard_if.slave sb
);

`ifdef SCOREBOARD_DEUCE_EN
  localparam bit DeuceEn = 1'b1;
`else
  localparam bit DeuceEn = 1'b0;
`endif
  localparam int unsigned CntW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

  typedef enum logic [0:0] {StPlay, StOver} state_e;

  state_e          state_q, state_d;
  logic [7:0]      left_q, left_d, right_q, right_d;
  logic            winner_q, winner_d;
  logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
  logic            hidden_q, hidden_d;
  logic [7:0][6:0] hex_q, hex_d;
  logic [7:0]      left_inc, right_inc;
  logic            hide_left, hide_right;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic int unsigned bcd_val(input logic [7:0] v);
    return 32'(v[7:4]) * 10 + 32'(v[3:0]);
  endfunction

  // s is the scorer's post-increment score, o the opponent's.
  function automatic logic wins(input logic [7:0] s, input logic [7:0] o);
    logic reached, lead;
    reached = bcd_val(s) >= WIN_SCORE;
    lead    = bcd_val(s) >= bcd_val(o) + 2;
    return (DeuceEn && s == 8'h99) || (reached && (!DeuceEn || lead));
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    right_d   = right_q;
    winner_d  = winner_q;
    left_inc  = bcd_inc(left_q);
    right_inc = bcd_inc(right_q);
    if (sb.new_match) begin
      state_d  = StPlay;
      left_d   = 8'h00;
      right_d  = 8'h00;
      winner_d = 1'b0;
    end else if (state_q == StPlay && (sb.goal_left ^ sb.goal_right)) begin
      if (sb.goal_left) begin
        left_d = left_inc;
        if (wins(left_inc, right_q)) begin
          state_d  = StOver;
          winner_d = 1'b0;
        end
      end else begin
        right_d = right_inc;
        if (wins(right_inc, left_q)) begin
          state_d  = StOver;
          winner_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + CntW'(1);
    hidden_d    = hidden_q;
    if (sb.new_match) begin
      blink_cnt_d = '0;
      hidden_d    = 1'b0;
    end else if (blink_cnt_q == CntMax) begin
      blink_cnt_d = '0;
      hidden_d    = ~hidden_q;
    end
  end

  // Display is built from the registered scores, hence one extra cycle of latency.
  always_comb begin
    hex_d      = '1;
    hide_left  = (state_q == StOver) && hidden_q && !winner_q;
    hide_right = (state_q == StOver) && hidden_q && winner_q;
    if (!hide_left) begin
      hex_d[7] = (left_q[7:4] == 4'd0) ? 7'b1111111 : seg7(left_q[7:4]);
      hex_d[6] = seg7(left_q[3:0]);
    end
    if (!hide_right) begin
      hex_d[1] = (right_q[7:4] == 4'd0) ? 7'b1111111 : seg7(right_q[7:4]);
      hex_d[0] = seg7(right_q[3:0]);
    end
  end

  always_ff @(posedge CLOCK2_50) begin
    if (rst) begin
      state_q     <= StPlay;
      left_q      <= 8'h00;
      right_q     <= 8'h00;
      winner_q    <= 1'b0;
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
      hex_q       <= '1;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      winner_q    <= winner_d;
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
      hex_q       <= hex_d;
    end
  end

  assign sb.score_left  = left_q;
  assign sb.score_right = right_q;
  assign sb.match_over  = (state_q == StOver);
  assign sb.winner      = winner_q;
  assign sb.HEX0        = hex_q[0];
  assign sb.HEX1        = hex_q[1];
  assign sb.HEX2        = hex_q[2];
  assign sb.HEX3        = hex_q[3];
  assign sb.HEX4        = hex_q[4];
  assign sb.HEX5        = hex_q[5];
  assign sb.HEX6        = hex_q[6];
  assign sb.HEX7        = hex_q[7];

endmodule

// File: tb/tb_pong_scoreboard.sv
// Directed bench for pong_scoreboard with a short blink period.
module tb_pong_scoreboard;
  localparam logic [6:0] Blank = 7'b1111111;
  localparam logic [6:0] Seg0  = 7'b1000000;
  localparam logic [6:0] Seg1  = 7'b1111001;
  localparam logic [6:0] Seg3  = 7'b0110000;

  logic CLOCK2_50 = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   failed = 0;

  pong_scoreboard_if sb ();

  pong_scoreboard #(
    .WIN_SCORE (11),
    .BLINK_DIV (4)
  ) dut (
    .CLOCK2_50 (CLOCK2_50),
    .rst       (rst),
    .sb        (sb)
  );

  always #5 CLOCK2_50 = ~CLOCK2_50;

  task automatic tick();
    @(posedge CLOCK2_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic goal_l(input int n);
    for (int i = 0; i < n; i++) begin
      sb.goal_left = 1'b1;
      tick();
      sb.goal_left = 1'b0;
    end
  endtask

  task automatic goal_r(input int n);
    for (int i = 0; i < n; i++) begin
      sb.goal_right = 1'b1;
      tick();
      sb.goal_right = 1'b0;
    end
  endtask

  task automatic new_match();
    sb.new_match = 1'b1;
    tick();
    sb.new_match = 1'b0;
  endtask

  logic [6:0] hv[16];
  int         t;

  initial begin
    sb.goal_left  = 1'b0;
    sb.goal_right = 1'b0;
    sb.new_match  = 1'b0;

    // Reset state
    tick();
    check("rst_left", sb.score_left, 8'h00);
    check("rst_right", sb.score_right, 8'h00);
    check("rst_over", {7'd0, sb.match_over}, 8'd0);
    check("rst_winner", {7'd0, sb.winner}, 8'd0);
    check("rst_hex7", {1'b0, sb.HEX7}, {1'b0, Blank});
    check("rst_hex0", {1'b0, sb.HEX0}, {1'b0, Blank});
    rst = 1'b0;

    // Three left goals
    goal_l(3);
    check("l3_score", sb.score_left, 8'h03);
    tick();
    check("l3_hex7", {1'b0, sb.HEX7}, {1'b0, Blank});
    check("l3_hex6", {1'b0, sb.HEX6}, {1'b0, Seg3});
    check("l3_hex1", {1'b0, sb.HEX1}, {1'b0, Blank});
    check("l3_hex0", {1'b0, sb.HEX0}, {1'b0, Seg0});
    check("l3_hex4", {1'b0, sb.HEX4}, {1'b0, Blank});

    // Ten right goals: units carry into tens
    goal_r(10);
    check("r10_score", sb.score_right, 8'h10);
    tick();
    check("r10_hex1", {1'b0, sb.HEX1}, {1'b0, Seg1});
    check("r10_hex0", {1'b0, sb.HEX0}, {1'b0, Seg0});

    // Simultaneous goals are dropped
    sb.goal_left  = 1'b1;
    sb.goal_right = 1'b1;
    tick();
    sb.goal_left  = 1'b0;
    sb.goal_right = 1'b0;
    check("both_left", sb.score_left, 8'h03);
    check("both_right", sb.score_right, 8'h10);

    // new_match wins over a same-cycle goal
    sb.new_match = 1'b1;
    sb.goal_left = 1'b1;
    tick();
    sb.new_match = 1'b0;
    sb.goal_left = 1'b0;
    check("nm_left", sb.score_left, 8'h00);
    check("nm_right", sb.score_right, 8'h00);
    check("nm_over", {7'd0, sb.match_over}, 8'd0);

    // Left wins 11-0
    goal_l(10);
    check("l10_over", {7'd0, sb.match_over}, 8'd0);
    goal_l(1);
    check("l11_score", sb.score_left, 8'h11);
    check("l11_over", {7'd0, sb.match_over}, 8'd1);
    check("l11_winner", {7'd0, sb.winner}, 8'd0);
    goal_r(2);
    check("over_ignore_r", sb.score_right, 8'h00);
    goal_l(1);
    check("over_ignore_l", sb.score_left, 8'h11);

    // Winner units digit blinks with a 4-cycle half-period, loser steady
    for (int i = 0; i < 16; i++) begin
      tick();
      hv[i] = sb.HEX6;
      check("blink_val", {7'd0, (sb.HEX6 === Seg1) || (sb.HEX6 === Blank)}, 8'd1);
      check("blink_hex0", {1'b0, sb.HEX0}, {1'b0, Seg0});
    end
    t = 0;
    for (int i = 15; i >= 1; i--) if (hv[i] !== hv[i-1]) t = i;
    check("blink_first", {7'd0, (t >= 1) && (t <= 4)}, 8'd1);
    for (int i = 1; i < 16; i++) begin
      if (t >= 1 && i > t) begin
        check("blink_period", {7'd0, hv[i] !== hv[i-1]}, {7'd0, ((i - t) % 4) == 0});
      end
    end

    // Deuce behaviour at 10-10
    new_match();
    for (int i = 0; i < 10; i++) begin
      goal_l(1);
      goal_r(1);
    end
    check("d_left", sb.score_left, 8'h10);
    check("d_right", sb.score_right, 8'h10);
    check("d_over", {7'd0, sb.match_over}, 8'd0);
    goal_l(1);
    check("d11_left", sb.score_left, 8'h11);
`ifdef SCOREBOARD_DEUCE_EN
    check("d11_over", {7'd0, sb.match_over}, 8'd0);
    goal_l(1);
    check("d12_left", sb.score_left, 8'h12);
    check("d12_over", {7'd0, sb.match_over}, 8'd1);
`else
    check("d11_over", {7'd0, sb.match_over}, 8'd1);
`endif
    check("d_winner", {7'd0, sb.winner}, 8'd0);

    // Right wins 0-11
    new_match();
    goal_r(11);
    check("rw_score", sb.score_right, 8'h11);
    check("rw_over", {7'd0, sb.match_over}, 8'd1);
    check("rw_winner", {7'd0, sb.winner}, 8'd1);

    // Reset while in OVER
    rst = 1'b1;
    tick();
    check("r2_left", sb.score_left, 8'h00);
    check("r2_right", sb.score_right, 8'h00);
    check("r2_over", {7'd0, sb.match_over}, 8'd0);
    check("r2_winner", {7'd0, sb.winner}, 8'd0);
    check("r2_hex0", {1'b0, sb.HEX0}, {1'b0, Blank});
    check("r2_hex1", {1'b0, sb.HEX1}, {1'b0, Blank});
    check("r2_hex6", {1'b0, sb.HEX6}, {1'b0, Blank});
    check("r2_hex7", {1'b0, sb.HEX7}, {1'b0, Blank});
    rst = 1'b0;
    goal_l(1);
    check("r2_goal", sb.score_left, 8'h01);

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end
endmodule
